flash_uart_streamer: RTL and testbench

Parametrised flash-to-UART streaming engine. It issues burst reads over a configurable flash address window through the SPI flash controller's request/ack read port and buffers the returned bytes in an internal FIFO. The bytes go out on the UART TX byte handshake, and received UART bytes are echoed with priority. It sits between `spi_flash_top` and the `uart_tx`/`uart_rx` byte interfaces as the generalised successor of the single-byte periodic flash dumper.

---
 rtl/flash_uart_streamer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_flash_uart_streamer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_uart_streamer.sv
`timescale 1ns/1ps
// flash_uart_streamer
//
// Streams a flash address window out over a UART TX byte interface. Every
// PERIOD_CYCLES the engine issues a burst read of up to BURST_LEN bytes to
// the SPI flash controller and pushes the returned bytes into a data FIFO.
// The FIFO drains onto the TX byte handshake in strict address order.
// Bytes received from the UART RX side are echoed through a one-entry slot
// that wins arbitration over the FIFO.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   enable                  run request (level)
//   single_pass             1: stop in DONE after one window pass, 0: wrap
//   flash_read*             request/ack burst read port of the flash ctrl
//   rx_data, rx_data_valid  received UART byte (one-cycle pulse)
//   tx_data*                UART TX byte handshake
//   busy, done              status (busy in WAIT/READ, done in DONE)
//   overflow, rx_drop       sticky error flags, cleared only by reset
//   dbg_state               current FSM state (0 IDLE, 1 WAIT, 2 READ, 3 DONE)
//
// TX handshake: a byte transfers on every rising clk edge where
// tx_data_valid and tx_data_ready are both high. Once raised, tx_data_valid
// and tx_data stay stable until that transfer; valid drops for one cycle
// after each transfer before the next byte is registered.
module flash_uart_streamer #(
    parameter int unsigned BURST_LEN     = 16,
    parameter int unsigned FIFO_DEPTH    = 32,
    parameter logic [23:0] START_ADDR    = 24'h000000,
    parameter logic [23:0] END_ADDR      = 24'h7FFFFF,
    parameter int unsigned PERIOD_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        single_pass,
    output logic        flash_read,
    output logic [23:0] flash_read_addr,
    output logic [8:0]  flash_read_size,
    input  logic        flash_read_ack,
    input  logic [7:0]  flash_read_data_out,
    input  logic        flash_read_data_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        rx_drop,
    output logic [1:0]  dbg_state
);

    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [24:0] END_EXT   = {1'b0, END_ADDR};
    localparam logic [31:0] PERIOD_M1 = 32'(PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       addr_q, addr_d;
    logic [31:0]       timer_q, timer_d;
    logic              flash_read_q, flash_read_d;
    logic [8:0]        size_q, size_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              echo_full_q, echo_full_d;
    logic [7:0]        echo_data_q, echo_data_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_src_echo_q, tx_src_echo_d;
    logic              overflow_q, overflow_d;
    logic              rx_drop_q, rx_drop_d;

    logic [7:0]        fifo_mem [FIFO_DEPTH];

    logic [24:0]       remaining;
    logic [8:0]        burst_size;
    logic [CNT_W-1:0]  fifo_free;
    logic              space_ok;
    logic              timer_done;
    logic [24:0]       next_addr;
    logic              tx_fire;
    logic              fifo_pop;
    logic              echo_clear;
    logic              fifo_full;
    logic              flash_byte;
    logic              fifo_wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Burst size is clipped so the last burst never reads past END_ADDR.
    always_comb begin
        remaining  = END_EXT - {1'b0, addr_q} + 25'd1;
        burst_size = (remaining >= 25'(BURST_LEN)) ? 9'(BURST_LEN) : remaining[8:0];
        fifo_free  = CNT_W'(FIFO_DEPTH) - count_q;
        space_ok   = (32'(fifo_free) >= 32'(burst_size));
        timer_done = (timer_q >= PERIOD_M1);
        next_addr  = {1'b0, addr_q} + 25'(size_q);
        tx_fire    = tx_valid_q & tx_data_ready;
        fifo_pop   = tx_fire & ~tx_src_echo_q;
        echo_clear = tx_fire & tx_src_echo_q;
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        flash_byte = (state_q == ST_READ) & flash_read_data_valid;
        // A pop in the same cycle frees the slot the write needs.
        fifo_wr    = flash_byte & (~fifo_full | fifo_pop);
    end

    // Control FSM
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        timer_d      = timer_q;
        flash_read_d = flash_read_q;
        size_d       = size_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    addr_d  = START_ADDR;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    // Saturate so a long wait for FIFO space cannot wrap.
                    if (timer_q != '1) timer_d = timer_q + 32'd1;
                    if (timer_done && space_ok) begin
                        flash_read_d = 1'b1;
                        size_d       = burst_size;
                        state_d      = ST_READ;
                    end
                end
            end
            ST_READ: begin
                // enable is only looked at on ack so a burst always completes.
                if (flash_read_ack) begin
                    flash_read_d = 1'b0;
                    timer_d      = '0;
                    if (next_addr > END_EXT) begin
                        addr_d  = START_ADDR;
                        state_d = single_pass ? ST_DONE : ST_WAIT;
                    end else begin
                        addr_d  = next_addr[23:0];
                        state_d = ST_WAIT;
                    end
                    if (!enable) state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO bookkeeping
    always_comb begin
        wr_ptr_d   = fifo_wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q;
        unique case ({fifo_wr, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (flash_byte & fifo_full & ~fifo_pop);
    end

    // Echo slot and TX arbiter
    always_comb begin
        echo_full_d   = echo_full_q;
        echo_data_d   = echo_data_q;
        rx_drop_d     = rx_drop_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        tx_src_echo_d = tx_src_echo_q;

        // The slot stays occupied while its byte sits on tx_data; it frees on
        // the handshake, and a byte arriving in that same cycle is accepted.
        if (echo_clear) echo_full_d = 1'b0;
        if (rx_data_valid) begin
            if (!echo_full_q || echo_clear) begin
                echo_full_d = 1'b1;
                echo_data_d = rx_data;
            end else begin
                rx_drop_d = 1'b1;
            end
        end

        if (tx_fire) begin
            tx_valid_d = 1'b0;
        end else if (!tx_valid_q) begin
            if (echo_full_q) begin
                tx_data_d     = echo_data_q;
                tx_valid_d    = 1'b1;
                tx_src_echo_d = 1'b1;
            end else if (count_q != '0) begin
                tx_data_d     = fifo_mem[rd_ptr_q];
                tx_valid_d    = 1'b1;
                tx_src_echo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= START_ADDR;
            timer_q       <= '0;
            flash_read_q  <= 1'b0;
            size_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            echo_full_q   <= 1'b0;
            echo_data_q   <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_src_echo_q <= 1'b0;
            overflow_q    <= 1'b0;
            rx_drop_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            timer_q       <= timer_d;
            flash_read_q  <= flash_read_d;
            size_q        <= size_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            echo_full_q   <= echo_full_d;
            echo_data_q   <= echo_data_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_src_echo_q <= tx_src_echo_d;
            overflow_q    <= overflow_d;
            rx_drop_q     <= rx_drop_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr_q] <= flash_read_data_out;
    end

    assign flash_read      = flash_read_q;
    assign flash_read_addr = addr_q;
    assign flash_read_size = size_q;
    assign tx_data         = tx_data_q;
    assign tx_data_valid   = tx_valid_q;
    assign busy            = (state_q == ST_WAIT) || (state_q == ST_READ);
    assign done            = (state_q == ST_DONE);
    assign overflow        = overflow_q;
    assign rx_drop         = rx_drop_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_flash_uart_streamer.sv
`timescale 1ns/1ps
// Directed bench for flash_uart_streamer with a small window
// (0x10..0x19, 4-byte bursts, 8-entry FIFO). The flash model answers each
// request with data = addr[7:0]; every TX handshake is checked against the
// expected byte queue.
module tb_flash_uart_streamer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        single_pass;
    logic        flash_read;
    logic [23:0] flash_read_addr;
    logic [8:0]  flash_read_size;
    logic        flash_read_ack;
    logic [7:0]  flash_read_data_out;
    logic        flash_read_data_valid;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        rx_drop;
    logic [1:0]  dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  exp_q[$];
    logic [32:0] req_q[$];

    flash_uart_streamer #(
        .BURST_LEN    (4),
        .FIFO_DEPTH   (8),
        .START_ADDR   (24'h000010),
        .END_ADDR     (24'h000019),
        .PERIOD_CYCLES(4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .single_pass          (single_pass),
        .flash_read           (flash_read),
        .flash_read_addr      (flash_read_addr),
        .flash_read_size      (flash_read_size),
        .flash_read_ack       (flash_read_ack),
        .flash_read_data_out  (flash_read_data_out),
        .flash_read_data_valid(flash_read_data_valid),
        .rx_data              (rx_data),
        .rx_data_valid        (rx_data_valid),
        .tx_data              (tx_data),
        .tx_data_valid        (tx_data_valid),
        .tx_data_ready        (tx_data_ready),
        .busy                 (busy),
        .done                 (done),
        .overflow             (overflow),
        .rx_drop              (rx_drop),
        .dbg_state            (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flash model: answers a request with one byte per cycle, then an ack.
    // A reset in the middle of a burst aborts it without an ack.
    logic [23:0] m_addr;
    logic [8:0]  m_size;
    logic        m_abort;
    initial begin
        flash_read_ack        = 1'b0;
        flash_read_data_valid = 1'b0;
        flash_read_data_out   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && flash_read) begin
                m_addr  = flash_read_addr;
                m_size  = flash_read_size;
                m_abort = 1'b0;
                req_q.push_back({m_addr, m_size});
                for (int i = 0; i < int'(m_size) && !m_abort; i++) begin
                    flash_read_data_out   = m_addr[7:0] + 8'(i);
                    flash_read_data_valid = 1'b1;
                    @(negedge clk);
                    flash_read_data_valid = 1'b0;
                    if (!rst_n) m_abort = 1'b1;
                end
                if (!m_abort) begin
                    flash_read_ack = 1'b1;
                    @(negedge clk);
                    flash_read_ack = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every TX handshake must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && tx_data_valid && tx_data_ready) begin
            if (exp_q.size() == 0)
                check("tx_unexpected", {56'd0, tx_data}, 64'h1FF);
            else
                check("tx_byte", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        enable        = 1'b0;
        rx_data_valid = 1'b0;
        tick(3);
        exp_q.delete();
        req_q.delete();
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        tick(1);
        rx_data_valid = 1'b0;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int b = lo; b <= hi; b++) exp_q.push_back(8'(b));
    endtask

    task automatic wait_req(input int n, input int budget);
        int cyc = 0;
        while (req_q.size() < n && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check("req_reached", 64'(req_q.size() >= n), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            tick(1);
            cyc++;
        end
        tick(4);
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_req(input string tag, input int idx, input logic [23:0] a, input logic [8:0] s);
        logic [32:0] got;
        got = (idx < req_q.size()) ? req_q[idx] : '1;
        check(tag, 64'(got), 64'({a, s}));
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        single_pass   = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        tx_data_ready = 1'b1;
        tick(3);

        // Reset values
        check("rst_flash_read", 64'(flash_read), 64'd0);
        check("rst_addr", 64'(flash_read_addr), 64'h10);
        check("rst_size", 64'(flash_read_size), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_tx_valid", 64'(tx_data_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_rx_drop", 64'(rx_drop), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Single pass
        single_pass = 1'b1;
        push_range(8'h10, 8'h19);
        enable = 1'b1;
        wait_req(3, 400);
        wait_drain(400);
        tick(30);
        check_req("sp_req0", 0, 24'h10, 9'd4);
        check_req("sp_req1", 1, 24'h14, 9'd4);
        check_req("sp_req2", 2, 24'h18, 9'd2);
        check("sp_req_count", 64'(req_q.size()), 64'd3);
        check("sp_done", 64'(done), 64'd1);
        check("sp_busy", 64'(busy), 64'd0);
        check("sp_flash_read", 64'(flash_read), 64'd0);
        enable = 1'b0;
        tick(2);
        check("sp_done_cleared", 64'(done), 64'd0);
        check("sp_state_idle", 64'(dbg_state), 64'd0);

        // Continuous wrap
        do_reset();
        single_pass = 1'b0;
        push_range(8'h10, 8'h19);
        push_range(8'h10, 8'h13);
        enable = 1'b1;
        wait_req(4, 600);
        enable = 1'b0;
        wait_drain(400);
        tick(10);
        check_req("wr_req2", 2, 24'h18, 9'd2);
        check_req("wr_req3", 3, 24'h10, 9'd4);
        check("wr_req_count", 64'(req_q.size()), 64'd4);
        check("wr_busy", 64'(busy), 64'd0);

        // Backpressure with echo priority and RX drop
        do_reset();
        tx_data_ready = 1'b0;
        single_pass   = 1'b1;
        enable        = 1'b1;
        tick(80);
        check("bp_req_count", 64'(req_q.size()), 64'd2);
        check("bp_overflow", 64'(overflow), 64'd0);
        check("bp_flash_read", 64'(flash_read), 64'd0);
        check("bp_tx_valid", 64'(tx_data_valid), 64'd1);
        check("bp_tx_data", 64'(tx_data), 64'h10);
        send_rx(8'h41);
        tick(2);
        send_rx(8'h42);
        tick(2);
        check("echo_rx_drop", 64'(rx_drop), 64'd1);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h41);
        push_range(8'h11, 8'h19);
        tx_data_ready = 1'b1;
        wait_drain(400);
        check_req("bp_req2", 2, 24'h18, 9'd2);
        check("bp_overflow_end", 64'(overflow), 64'd0);
        check("bp_done", 64'(done), 64'd1);
        check("bp_rx_drop_sticky", 64'(rx_drop), 64'd1);
        enable = 1'b0;
        tick(2);

        // Enable dropped mid-burst
        do_reset();
        single_pass = 1'b1;
        push_range(8'h10, 8'h13);
        enable = 1'b1;
        wait_req(1, 200);
        enable = 1'b0;
        check("en_hold_flash_read", 64'(flash_read), 64'd1);
        check("en_busy_in_read", 64'(busy), 64'd1);
        for (int c = 0; c < 50 && flash_read; c++) tick(1);
        check("en_flash_read_released", 64'(flash_read), 64'd0);
        tick(2);
        check("en_busy_after", 64'(busy), 64'd0);
        check("en_state_idle", 64'(dbg_state), 64'd0);
        wait_drain(200);
        req_q.delete();
        push_range(8'h10, 8'h19);
        enable = 1'b1;
        wait_req(1, 200);
        check_req("en_restart_req", 0, 24'h10, 9'd4);
        wait_drain(400);
        enable = 1'b0;
        tick(2);

        // Reset in the middle of a burst
        do_reset();
        tx_data_ready = 1'b0;
        single_pass   = 1'b1;
        send_rx(8'h41);
        tick(2);
        send_rx(8'h42);
        tick(1);
        check("rs_pre_rx_drop", 64'(rx_drop), 64'd1);
        enable = 1'b1;
        wait_req(1, 200);
        tick(2);
        check("rs_pre_flash_read", 64'(flash_read), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rs_flash_read", 64'(flash_read), 64'd0);
        check("rs_tx_valid", 64'(tx_data_valid), 64'd0);
        check("rs_tx_data", 64'(tx_data), 64'd0);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_rx_drop", 64'(rx_drop), 64'd0);
        check("rs_overflow", 64'(overflow), 64'd0);
        check("rs_addr", 64'(flash_read_addr), 64'h10);
        check("rs_size", 64'(flash_read_size), 64'd0);
        enable = 1'b0;
        tick(3);
        exp_q.delete();
        req_q.delete();
        rst_n = 1'b1;
        tick(6);
        check("rs_fifo_empty", 64'(tx_data_valid), 64'd0);
        tx_data_ready = 1'b1;
        push_range(8'h10, 8'h19);
        enable = 1'b1;
        wait_req(1, 200);
        check_req("rs_first_req", 0, 24'h10, 9'd4);
        wait_drain(400);
        check("rs_done", 64'(done), 64'd1);
        enable = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
